// File: rtl/conv_mac_unit.sv
// conv_mac_unit: multi-lane convolution MAC. Holds a KxK weight store and,
// once started, consumes one window tap per valid cycle on every lane in
// parallel, presenting the per-lane dot products for one cycle when done.
module conv_mac_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 2,
  parameter int IMAGE_WIDTH = 8,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           en,
  input  logic                                           start,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]                 kernel_dim,
  input  logic                                           weight_we,
  input  logic [$clog2(IMAGE_WIDTH*IMAGE_WIDTH)-1:0]     weight_addr,
  input  logic [DATA_WIDTH-1:0]                          weight_in,
  input  logic                                           data_valid,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]           data_in,
  output logic                                           step,
  output logic [NUM_UNITS-1:0][ACC_WIDTH-1:0]            result,
  output logic                                           result_valid,
  output logic                                           busy
);

  localparam int KDIM_W = $clog2(IMAGE_WIDTH);
  localparam int TAP_W  = $clog2(IMAGE_WIDTH*IMAGE_WIDTH);
  localparam int DEPTH  = IMAGE_WIDTH*IMAGE_WIDTH;
  localparam int PROD_W = 2*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q, state_d;
  logic        [TAP_W-1:0]        tap_p0;
  logic        [TAP_W-1:0]        total_p0;
  logic signed [ACC_WIDTH-1:0]    acc_p0 [NUM_UNITS];
  logic signed [DATA_WIDTH-1:0]   w_mem  [DEPTH];

  logic                           launch;
  logic                           consume;
  logic        [TAP_W-1:0]        kdim_ext;
  logic        [TAP_W-1:0]        last_tap;

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] ae;
    logic signed [PROD_W-1:0] be;
    logic signed [PROD_W-1:0] p;
    ae = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    be = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    p  = ae * be;
    return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  assign kdim_ext = {{(TAP_W-KDIM_W){1'b0}}, kernel_dim};
  assign last_tap = total_p0 - TAP_W'(1);
  assign launch   = (state_q == IDLE) && start && en && (kernel_dim != '0);
  assign consume  = (state_q == RUN) && en && data_valid;

  assign step         = (state_q == RUN) && en;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: the final accumulate edge also moves RUN to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (consume && (tap_p0 == last_tap)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap counter and lane accumulators; cleared on launch, advanced per valid tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_p0   <= '0;
      total_p0 <= '0;
      for (int i = 0; i < NUM_UNITS; i++) acc_p0[i] <= '0;
    end else if (launch) begin
      tap_p0   <= '0;
      total_p0 <= kdim_ext * kdim_ext;
      for (int i = 0; i < NUM_UNITS; i++) acc_p0[i] <= '0;
    end else if (consume) begin
      tap_p0 <= tap_p0 + TAP_W'(1);
      for (int i = 0; i < NUM_UNITS; i++)
        acc_p0[i] <= acc_p0[i] + mac_term(data_in[i], w_mem[tap_p0]);
    end
  end

  // Weight store: writable only between windows, never reset.
  always_ff @(posedge clk) begin
    if (weight_we && (state_q == IDLE)) w_mem[weight_addr] <= weight_in;
  end

  // Accumulators double as the result holding register until the next launch.
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_res
    assign result[g] = acc_p0[g];
  end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Testbench for conv_mac_unit: directed windows with a result scoreboard.
module tb_conv_mac_unit;

  localparam int DW = 16;
  localparam int NU = 2;
  localparam int IW = 8;
  localparam int AW = 40;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          en;
  logic                          start;
  logic [$clog2(IW)-1:0]         kernel_dim;
  logic                          weight_we;
  logic [$clog2(IW*IW)-1:0]      weight_addr;
  logic [DW-1:0]                 weight_in;
  logic                          data_valid;
  logic [NU-1:0][DW-1:0]         data_in;
  logic                          step;
  logic [NU-1:0][AW-1:0]         result;
  logic                          result_valid;
  logic                          busy;

  typedef struct {
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  conv_mac_unit #(
    .DATA_WIDTH(DW), .NUM_UNITS(NU), .IMAGE_WIDTH(IW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .kernel_dim(kernel_dim),
    .weight_we(weight_we), .weight_addr(weight_addr), .weight_in(weight_in),
    .data_valid(data_valid), .data_in(data_in), .step(step), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input logic signed [DW-1:0] val);
    weight_we   = 1'b1;
    weight_addr = 6'(addr);
    weight_in   = val;
    tick();
    weight_we   = 1'b0;
  endtask

  task automatic start_win(input int k);
    start      = 1'b1;
    kernel_dim = 3'(k);
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    data_valid = 1'b1;
    data_in[0] = a;
    data_in[1] = b;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic push(input logic signed [AW-1:0] r0, input logic signed [AW-1:0] r1);
    exp_t e;
    e.r0 = r0;
    e.r1 = r1;
    sb_q.push_back(e);
  endtask

  // Monitor: every result_valid pulse must match the oldest expected window.
  always @(negedge clk) begin
    exp_t e;
    if (reset && result_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got pulse expected none");
      end else begin
        e = sb_q.pop_front();
        chk("result_lane0", 64'(result[0]), 64'(e.r0));
        chk("result_lane1", 64'(result[1]), 64'(e.r1));
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b1; start = 1'b0; kernel_dim = '0;
    weight_we = 1'b0; weight_addr = '0; weight_in = '0;
    data_valid = 1'b0; data_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_step", 64'(step), 64'(0));
    chk("rst_rvalid", 64'(result_valid), 64'(0));
    reset = 1'b1;
    tick();

    // Basic K=2
    for (int i = 0; i < 4; i++) write_w(i, 16'(i + 1));
    push(40'sd10, 40'sd11);
    start_win(2);
    chk("basic_busy", 64'(busy), 64'(1));
    chk("basic_step", 64'(step), 64'(1));
    feed(16'sd1, 16'sd2);
    feed(16'sd1, 16'sd0);
    feed(16'sd1, -16'sd1);
    chk("basic_no_early_rv", 64'(result_valid), 64'(0));
    feed(16'sd1, 16'sd3);
    chk("basic_rv", 64'(result_valid), 64'(1));
    chk("basic_done_step", 64'(step), 64'(0));
    tick();
    chk("basic_rv_one_cycle", 64'(result_valid), 64'(0));
    chk("basic_idle_busy", 64'(busy), 64'(0));

    // Stall: 3 data_valid-low cycles then 2 en-low cycles
    push(40'sd10, 40'sd11);
    start_win(2);
    feed(16'sd1, 16'sd2);
    feed(16'sd1, 16'sd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_dv_step", 64'(step), 64'(1));
      tick();
      chk("stall_dv_rv", 64'(result_valid), 64'(0));
    end
    en = 1'b0;
    data_valid = 1'b1;
    data_in[0] = 16'sd1;
    data_in[1] = -16'sd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_en_step", 64'(step), 64'(0));
      tick();
      chk("stall_en_busy", 64'(busy), 64'(1));
    end
    en = 1'b1;
    feed(16'sd1, -16'sd1);
    chk("stall_no_early_rv", 64'(result_valid), 64'(0));
    feed(16'sd1, 16'sd3);
    chk("stall_rv", 64'(result_valid), 64'(1));
    tick();

    // Sign and width: K=1, extreme operands
    write_w(0, -16'sd32768);
    push(40'sd1073741824, -40'sd1073709056);
    start_win(1);
    feed(-16'sd32768, 16'sd32767);
    chk("sign_rv", 64'(result_valid), 64'(1));
    tick();

    // Guard: K=0 start ignored; weight write in RUN ignored
    write_w(0, 16'sd5);
    start_win(0);
    chk("guard_k0_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    chk("guard_k0_busy_later", 64'(busy), 64'(0));
    push(40'sd15, -40'sd10);
    start_win(1);
    weight_we = 1'b1; weight_addr = '0; weight_in = 16'sd100;
    tick();
    weight_we = 1'b0;
    feed(16'sd3, -16'sd2);
    tick();
    push(40'sd5, 40'sd5);
    start_win(1);
    feed(16'sd1, 16'sd1);
    tick();

    // Reset mid-window, then a clean K=3 window
    for (int i = 0; i < 9; i++) write_w(i, 16'(i + 1));
    start_win(3);
    feed(16'sd1, 16'sd1);
    feed(16'sd1, 16'sd2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_step", 64'(step), 64'(0));
    chk("midrst_rv", 64'(result_valid), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    push(40'sd45, 40'sd285);
    start_win(3);
    for (int k = 1; k <= 9; k++) feed(16'sd1, 16'(k));
    chk("rst_win_rv", 64'(result_valid), 64'(1));
    tick();

    // Back-to-back windows
    push(40'sd20, 40'sd10);
    start_win(2);
    for (int i = 0; i < 4; i++) feed(16'sd2, 16'sd1);
    chk("b2b_rv", 64'(result_valid), 64'(1));
    tick();
    chk("b2b_hold_lane0", 64'(result[0]), 64'(20));
    chk("b2b_hold_lane1", 64'(result[1]), 64'(10));
    push(40'sd1, -40'sd4);
    start_win(2);
    feed(16'sd1, 16'sd0);
    feed(16'sd0, 16'sd0);
    feed(16'sd0, 16'sd0);
    feed(16'sd0, -16'sd1);
    chk("b2b2_rv", 64'(result_valid), 64'(1));
    tick();

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
